ycrcb_blob_centroid: RTL and testbench
======================================

Name: ycrcb_blob_centroid

Overview:
- Consumes the YCrCb pixel stream from the colour-space converter, which is 3 cycles of latency behind the RGB input. Pipeline alignment of hcount/vcount/valid is the caller's job.
- Classifies each pixel against programmable Y/Cr/Cb thresholds and emits a per-pixel mask.
- Accumulates the x-sum, y-sum and count of masked pixels over a frame.
- At end of frame, runs two sequential dividers and publishes the blob centroid and area for the downstream tracking/overlay logic.

Parameters:
- H_ACTIVE, 1280, active pixels per line; pixels with hcount_in >= H_ACTIVE are ignored.
- V_ACTIVE, 720, active lines per frame; pixels with vcount_in >= V_ACTIVE are ignored.

Ports:
- clk_in  input  1  pixel clock.
- rst_n_in  input  1  asynchronous active-low reset.
- valid_in  input  1  pixel qualifier for y/cr/cb/hcount/vcount.
- hcount_in  input  11  pixel x coordinate.
- vcount_in  input  10  pixel y coordinate.
- y_in  input  10  luma.
- cr_in  input  10  Cr chroma.
- cb_in  input  10  Cb chroma.
- frame_done_in  input  1  single-cycle end-of-frame strobe.
- y_min_in  input  10  minimum luma, inclusive.
- cr_lo_in  input  10  Cr lower bound, inclusive.
- cr_hi_in  input  10  Cr upper bound, inclusive.
- cb_lo_in  input  10  Cb lower bound, inclusive.
- cb_hi_in  input  10  Cb upper bound, inclusive.
- mask_out  output  1  pixel passed thresholds.
- mask_valid_out  output  1  registered copy of valid_in.
- x_center_out  output  11  centroid x, floor division.
- y_center_out  output  10  centroid y, floor division.
- area_out  output  20  masked pixel count of the last completed frame.
- centroid_valid_out  output  1  one-cycle strobe when the centroid outputs update.
- busy_out  output  1  divider active.
- overrun_out  output  1  one-cycle strobe when frame_done_in is dropped.

Behaviour:
- Reset: while rst_n_in is low, all outputs, accumulators, divider registers and state are 0; FSM state is IDLE. Reset asserted mid-divide aborts the divide with no valid strobe.
- Mask:
  - hit = valid_in && hcount_in < H_ACTIVE && vcount_in < V_ACTIVE && y_in >= y_min_in && cr_lo_in <= cr_in <= cr_hi_in && cb_lo_in <= cb_in <= cb_hi_in.
  - mask_out and mask_valid_out are registered, 1-cycle latency.
  - If lo > hi, the pixel never matches.
  - Thresholds are sampled every cycle; no shadowing.
- Accumulators:
  - sum_x and sum_y are 31 bits; count is 20 bits. They are unsigned and cannot overflow at the default parameters.
  - On a hit: sum_x += hcount_in, sum_y += vcount_in, count += 1.
- Frame-done edge:
  - Accumulators are cleared on every cycle that frame_done_in is high.
  - A hit on that same cycle belongs to the ending frame: it is included in the snapshot, and the accumulators are then cleared to 0, not to the new pixel.
- FSM IDLE -> DIVIDE -> DONE -> IDLE:
  - IDLE: on frame_done_in, snapshot sum_x, sum_y and count into the divider, go to DIVIDE, iteration counter = 0, busy_out = 1.
  - DIVIDE: two parallel restoring dividers, 31-bit dividend by 20-bit divisor, 1 quotient bit per cycle, 31 iterations. After the 31st iteration go to DONE.
  - DONE: register the quotients into x_center_out/y_center_out (low 11 and 10 bits), register count into area_out, pulse centroid_valid_out, go to IDLE, busy_out = 0.
  - Latency: if frame_done_in is sampled at edge k, centroid_valid_out is high for exactly the cycle following edge k+32.
  - count == 0: the divide still runs for fixed latency; results are forced to x = 0, y = 0, area = 0; valid still pulses.
- Overrun:
  - frame_done_in while in DIVIDE or DONE: accumulators are still cleared and no new divide starts.
  - overrun_out pulses on the following cycle.
  - The in-flight result completes unaffected.
- Outputs hold their values between strobes.

Test Plan:
- Single hit: thresholds cr 500..600, cb 400..450, y_min 100; pixel (100,50) with y=200, cr=550, cb=420, then frame_done -> mask_out=1 one cycle later; 32 cycles after frame_done: x=100, y=50, area=1, centroid_valid_out=1 for 1 cycle.
- Floor rounding: hits at (10,0) and (13,0) -> x=11, y=0, area=2.
- Boundary: cr_in=500 matches and cr_in=499 does not; cb_in=451 does not; y_in=99 does not; hcount_in=1280 ignored even with matching colour.
- Empty frame: no hits then frame_done -> x=0, y=0, area=0, valid strobe still at +32.
- Overrun and same-cycle hit:
  - frame_done at k with a hit on the same cycle -> that hit is counted.
  - Second frame_done at k+5 -> overrun_out at k+6; result of the first frame is unchanged; the next frame starts from an empty count.
- Reset mid-divide: drop rst_n_in at k+10 -> all outputs 0 immediately; no centroid_valid_out; the next frame works normally.

Source files
------------

// File: rtl/ycrcb_blob_centroid.sv
// ycrcb_blob_centroid: threshold YCrCb pixels into a mask and publish the per-frame blob centroid and area
module ycrcb_blob_centroid #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        valid_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic [9:0]  y_in,
  input  logic [9:0]  cr_in,
  input  logic [9:0]  cb_in,
  input  logic        frame_done_in,
  input  logic [9:0]  y_min_in,
  input  logic [9:0]  cr_lo_in,
  input  logic [9:0]  cr_hi_in,
  input  logic [9:0]  cb_lo_in,
  input  logic [9:0]  cb_hi_in,
  output logic        mask_out,
  output logic        mask_valid_out,
  output logic [10:0] x_center_out,
  output logic [9:0]  y_center_out,
  output logic [19:0] area_out,
  output logic        centroid_valid_out,
  output logic        busy_out,
  output logic        overrun_out
);
  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;
  localparam logic [11:0] LP_H = 12'(H_ACTIVE);
  localparam logic [10:0] LP_V = 11'(V_ACTIVE);
  state_t      r_state;
  logic        r_mask, r_mask_valid, r_valid, r_busy, r_overrun;
  logic [30:0] r_sum_x, r_sum_y, r_qx, r_qy;
  logic [19:0] r_cnt, r_den, r_rem_x, r_rem_y, r_area;
  logic [10:0] r_x;
  logic [9:0]  r_y;
  logic [4:0]  r_it;
  logic        w_hit, w_ge_x, w_ge_y;
  logic [30:0] w_snap_x, w_snap_y;
  logic [19:0] w_snap_n;
  logic [20:0] w_rx, w_ry;
  assign w_hit = valid_in && ({1'b0, hcount_in} < LP_H) && ({1'b0, vcount_in} < LP_V) &&
                 (y_in >= y_min_in) && (cr_in >= cr_lo_in) && (cr_in <= cr_hi_in) &&
                 (cb_in >= cb_lo_in) && (cb_in <= cb_hi_in);
  // a hit on the frame_done cycle still belongs to the ending frame
  assign w_snap_x = r_sum_x + (w_hit ? {20'd0, hcount_in} : 31'd0);
  assign w_snap_y = r_sum_y + (w_hit ? {21'd0, vcount_in} : 31'd0);
  assign w_snap_n = r_cnt + {19'd0, w_hit};
  // restoring divide step: shift in the next dividend bit, subtract when it fits
  assign w_rx   = {r_rem_x, r_qx[30]};
  assign w_ry   = {r_rem_y, r_qy[30]};
  assign w_ge_x = w_rx >= {1'b0, r_den};
  assign w_ge_y = w_ry >= {1'b0, r_den};
  assign mask_out           = r_mask;
  assign mask_valid_out     = r_mask_valid;
  assign x_center_out       = r_x;
  assign y_center_out       = r_y;
  assign area_out           = r_area;
  assign centroid_valid_out = r_valid;
  assign busy_out           = r_busy;
  assign overrun_out        = r_overrun;
  // per-pixel mask with one cycle of latency
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      r_mask       <= 1'b0;
      r_mask_valid <= 1'b0;
    end else begin
      r_mask       <= w_hit;
      r_mask_valid <= valid_in;
    end
  // frame accumulators, cleared on every frame_done regardless of divider state
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      r_sum_x <= '0;
      r_sum_y <= '0;
      r_cnt   <= '0;
    end else if (frame_done_in) begin
      r_sum_x <= '0;
      r_sum_y <= '0;
      r_cnt   <= '0;
    end else if (w_hit) begin
      r_sum_x <= w_snap_x;
      r_sum_y <= w_snap_y;
      r_cnt   <= w_snap_n;
    end
  // snapshot, 31-step divide, publish; frame_done while busy only raises overrun
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      r_state   <= IDLE;
      r_qx      <= '0;
      r_qy      <= '0;
      r_rem_x   <= '0;
      r_rem_y   <= '0;
      r_den     <= '0;
      r_it      <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_area    <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_overrun <= frame_done_in && (r_state != IDLE);
      case (r_state)
        IDLE: if (frame_done_in) begin
          r_qx    <= w_snap_x;
          r_qy    <= w_snap_y;
          r_den   <= w_snap_n;
          r_rem_x <= '0;
          r_rem_y <= '0;
          r_it    <= '0;
          r_busy  <= 1'b1;
          r_state <= DIVIDE;
        end
        DIVIDE: begin
          r_qx    <= {r_qx[29:0], w_ge_x};
          r_qy    <= {r_qy[29:0], w_ge_y};
          r_rem_x <= w_ge_x ? w_rx[19:0] - r_den : w_rx[19:0];
          r_rem_y <= w_ge_y ? w_ry[19:0] - r_den : w_ry[19:0];
          r_it    <= r_it + 5'd1;
          if (r_it == 5'd30) r_state <= DONE;
        end
        DONE: begin
          r_x     <= (r_den == '0) ? 11'd0 : r_qx[10:0];
          r_y     <= (r_den == '0) ? 10'd0 : r_qy[9:0];
          r_area  <= r_den;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ycrcb_blob_centroid.sv
// tb_ycrcb_blob_centroid: directed checks of mask, centroid timing, boundaries, overrun and reset
module tb_ycrcb_blob_centroid;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic [9:0]  y = '0, cr = '0, cb = '0;
  logic        fd = 1'b0;
  logic [9:0]  y_min = 10'd100, cr_lo = 10'd500, cr_hi = 10'd600, cb_lo = 10'd400, cb_hi = 10'd450;
  logic        mask, mask_valid, cv, busy, ov;
  logic [10:0] xc;
  logic [9:0]  yc;
  logic [19:0] area;
  int n_pass = 0;
  int n_tot = 0;

  always #5 clk = ~clk;

  ycrcb_blob_centroid dut (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid), .hcount_in(hcount), .vcount_in(vcount),
    .y_in(y), .cr_in(cr), .cb_in(cb), .frame_done_in(fd),
    .y_min_in(y_min), .cr_lo_in(cr_lo), .cr_hi_in(cr_hi), .cb_lo_in(cb_lo), .cb_hi_in(cb_hi),
    .mask_out(mask), .mask_valid_out(mask_valid), .x_center_out(xc), .y_center_out(yc),
    .area_out(area), .centroid_valid_out(cv), .busy_out(busy), .overrun_out(ov)
  );

  // one pixel cycle; returns 1ns after the sampling edge with inputs idled
  task automatic pix(input logic v, input logic [10:0] h, input logic [9:0] vc,
                     input logic [9:0] yy, input logic [9:0] r, input logic [9:0] b, input logic f);
    @(negedge clk);
    valid = v; hcount = h; vcount = vc; y = yy; cr = r; cb = b; fd = f;
    @(posedge clk);
    #1;
    valid = 1'b0; fd = 1'b0;
  endtask

  // observe up to 40 cycles after a frame_done edge, recording the centroid strobe
  task automatic collect(output int first, output int n, output logic [10:0] x,
                         output logic [9:0] yo, output logic [19:0] a);
    first = -1; n = 0; x = '0; yo = '0; a = '0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (cv) begin
        n++;
        if (first < 0) begin first = i; x = xc; yo = yc; a = area; end
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_tot++; if ({mask, mask_valid, cv, busy, ov} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {mask, mask_valid, cv, busy, ov}); else n_pass++;
    n_tot++; if ({xc, yc} !== 21'd0) $display("FAIL reset_xy: got %0d,%0d want 0,0", xc, yc); else n_pass++;
    n_tot++; if (area !== 20'd0) $display("FAIL reset_area: got %0d want 0", area); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_hit;
    int first, n;
    logic [10:0] x; logic [9:0] yo; logic [19:0] a;
    pix(1, 100, 50, 200, 550, 420, 0);
    n_tot++; if (mask !== 1'b1) $display("FAIL single_mask: got %b want 1", mask); else n_pass++;
    n_tot++; if (mask_valid !== 1'b1) $display("FAIL single_mask_valid: got %b want 1", mask_valid); else n_pass++;
    pix(0, 0, 0, 0, 0, 0, 1);
    n_tot++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
    n_tot++; if (mask_valid !== 1'b0) $display("FAIL single_mask_valid_low: got %b want 0", mask_valid); else n_pass++;
    collect(first, n, x, yo, a);
    n_tot++; if (first !== 32) $display("FAIL single_latency: got %0d want 32", first); else n_pass++;
    n_tot++; if (n !== 1) $display("FAIL single_pulses: got %0d want 1", n); else n_pass++;
    n_tot++; if (x !== 11'd100) $display("FAIL single_x: got %0d want 100", x); else n_pass++;
    n_tot++; if (yo !== 10'd50) $display("FAIL single_y: got %0d want 50", yo); else n_pass++;
    n_tot++; if (a !== 20'd1) $display("FAIL single_area: got %0d want 1", a); else n_pass++;
    n_tot++; if (busy !== 1'b0) $display("FAIL single_busy_clear: got %b want 0", busy); else n_pass++;
    n_tot++; if (area !== 20'd1) $display("FAIL single_hold: got %0d want 1", area); else n_pass++;
  endtask

  task automatic test_floor;
    int first, n;
    logic [10:0] x; logic [9:0] yo; logic [19:0] a;
    pix(1, 10, 0, 200, 550, 420, 0);
    pix(1, 13, 0, 200, 550, 420, 0);
    pix(0, 0, 0, 0, 0, 0, 1);
    collect(first, n, x, yo, a);
    n_tot++; if (x !== 11'd11) $display("FAIL floor_x: got %0d want 11", x); else n_pass++;
    n_tot++; if (yo !== 10'd0) $display("FAIL floor_y: got %0d want 0", yo); else n_pass++;
    n_tot++; if (a !== 20'd2) $display("FAIL floor_area: got %0d want 2", a); else n_pass++;
  endtask

  task automatic test_boundary;
    int first, n;
    logic [10:0] x; logic [9:0] yo; logic [19:0] a;
    pix(1, 20, 30, 200, 500, 420, 0);
    n_tot++; if (mask !== 1'b1) $display("FAIL bnd_cr500: got %b want 1", mask); else n_pass++;
    pix(1, 21, 30, 200, 499, 420, 0);
    n_tot++; if (mask !== 1'b0) $display("FAIL bnd_cr499: got %b want 0", mask); else n_pass++;
    pix(1, 22, 30, 200, 550, 451, 0);
    n_tot++; if (mask !== 1'b0) $display("FAIL bnd_cb451: got %b want 0", mask); else n_pass++;
    pix(1, 23, 30, 99, 550, 420, 0);
    n_tot++; if (mask !== 1'b0) $display("FAIL bnd_y99: got %b want 0", mask); else n_pass++;
    pix(1, 1280, 30, 200, 550, 420, 0);
    n_tot++; if (mask !== 1'b0) $display("FAIL bnd_h1280: got %b want 0", mask); else n_pass++;
    pix(1, 24, 720, 200, 550, 420, 0);
    n_tot++; if (mask !== 1'b0) $display("FAIL bnd_v720: got %b want 0", mask); else n_pass++;
    cr_lo = 10'd600; cr_hi = 10'd500;
    pix(1, 25, 30, 200, 550, 420, 0);
    n_tot++; if (mask !== 1'b0) $display("FAIL bnd_lo_gt_hi: got %b want 0", mask); else n_pass++;
    cr_lo = 10'd500; cr_hi = 10'd600;
    pix(0, 0, 0, 0, 0, 0, 1);
    collect(first, n, x, yo, a);
    n_tot++; if ({x, yo, a} !== {11'd20, 10'd30, 20'd1}) $display("FAIL bnd_result: got %0d,%0d,%0d want 20,30,1", x, yo, a); else n_pass++;
  endtask

  task automatic test_empty;
    int first, n;
    logic [10:0] x; logic [9:0] yo; logic [19:0] a;
    pix(1, 5, 5, 50, 550, 420, 0);
    pix(0, 0, 0, 0, 0, 0, 1);
    collect(first, n, x, yo, a);
    n_tot++; if (first !== 32) $display("FAIL empty_latency: got %0d want 32", first); else n_pass++;
    n_tot++; if ({x, yo} !== 21'd0) $display("FAIL empty_xy: got %0d,%0d want 0,0", x, yo); else n_pass++;
    n_tot++; if (a !== 20'd0) $display("FAIL empty_area: got %0d want 0", a); else n_pass++;
  endtask

  task automatic test_overrun;
    int first, n, ov_at, ov_n;
    logic [10:0] x; logic [9:0] yo; logic [19:0] a;
    first = -1; n = 0; ov_at = -1; ov_n = 0; x = '0; yo = '0; a = '0;
    pix(1, 7, 9, 200, 550, 420, 0);
    pix(1, 9, 11, 200, 550, 420, 1);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 5) begin
        valid = 1'b1; hcount = 11'd500; vcount = 10'd500; y = 10'd200; cr = 10'd550; cb = 10'd420; fd = 1'b1;
      end else begin
        valid = 1'b0; fd = 1'b0;
      end
      @(posedge clk);
      #1;
      if (ov) begin ov_n++; if (ov_at < 0) ov_at = i; end
      if (cv) begin n++; if (first < 0) begin first = i; x = xc; yo = yc; a = area; end end
    end
    n_tot++; if (ov_at !== 5) $display("FAIL ovr_when: got %0d want 5", ov_at); else n_pass++;
    n_tot++; if (ov_n !== 1) $display("FAIL ovr_pulses: got %0d want 1", ov_n); else n_pass++;
    n_tot++; if (first !== 32) $display("FAIL ovr_latency: got %0d want 32", first); else n_pass++;
    n_tot++; if (n !== 1) $display("FAIL ovr_valid_pulses: got %0d want 1", n); else n_pass++;
    n_tot++; if ({x, yo, a} !== {11'd8, 10'd10, 20'd2}) $display("FAIL ovr_result: got %0d,%0d,%0d want 8,10,2", x, yo, a); else n_pass++;
    pix(1, 30, 40, 200, 550, 420, 0);
    pix(0, 0, 0, 0, 0, 0, 1);
    collect(first, n, x, yo, a);
    n_tot++; if ({x, yo, a} !== {11'd30, 10'd40, 20'd1}) $display("FAIL ovr_next_frame: got %0d,%0d,%0d want 30,40,1", x, yo, a); else n_pass++;
  endtask

  task automatic test_reset_mid_divide;
    int first, n;
    logic [10:0] x; logic [9:0] yo; logic [19:0] a;
    pix(1, 5, 5, 200, 550, 420, 1);
    repeat (9) @(posedge clk);
    #2;
    n_tot++; if (busy !== 1'b1) $display("FAIL rstmid_busy: got %b want 1", busy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_tot++; if ({mask, mask_valid, cv, busy, ov} !== 5'b0) $display("FAIL rstmid_flags: got %b want 00000", {mask, mask_valid, cv, busy, ov}); else n_pass++;
    n_tot++; if ({xc, yc, area} !== 41'd0) $display("FAIL rstmid_outputs: got %0d,%0d,%0d want 0,0,0", xc, yc, area); else n_pass++;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (cv) n++;
    end
    n_tot++; if (n !== 0) $display("FAIL rstmid_no_valid: got %0d want 0", n); else n_pass++;
    pix(1, 64, 32, 200, 550, 420, 0);
    pix(0, 0, 0, 0, 0, 0, 1);
    collect(first, n, x, yo, a);
    n_tot++; if (first !== 32) $display("FAIL rstmid_next_latency: got %0d want 32", first); else n_pass++;
    n_tot++; if ({x, yo, a} !== {11'd64, 10'd32, 20'd1}) $display("FAIL rstmid_next: got %0d,%0d,%0d want 64,32,1", x, yo, a); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_single_hit;
    test_floor;
    test_boundary;
    test_empty;
    test_overrun;
    test_reset_mid_divide;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
